// File: rtl/vram_fill_engine.sv
// vram_fill_engine: fills a programmable word range of the video RAM with a constant or
// incrementing pattern through a request/grant write port. Optionally clears the whole RAM
// once after reset.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   start_i        start pulse, accepted only in idle
//   abort_i        stop an in-progress fill, sampled only while filling
//   cfg_base_i     first word address (latched on start)
//   cfg_count_i    number of words to write (latched on start)
//   cfg_pattern_i  fill value / increment seed (latched on start)
//   cfg_mode_i     0 = constant, 1 = incrementing (latched on start)
//   wr_req_o       write request to the VRAM arbiter
//   wr_gnt_i       arbiter grant; a write is accepted on wr_req_o && wr_gnt_i
//   wr_addr_o      VRAM word address
//   wr_be_o        byte enables, all set while requesting
//   wr_data_o      write data
//   busy_o         high while filling
//   done_o         one-cycle completion pulse
//   cfg_err_o      pulses with done_o when the request was clipped or empty
module vram_fill_engine #(
  parameter int unsigned              ADDR_W         = 11,
  parameter int unsigned              DEPTH          = 600,
  parameter int unsigned              DATA_W         = 32,
  parameter int unsigned              START_ON_RESET = 1,
  parameter logic [DATA_W-1:0]        FILL_INIT      = '0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ADDR_W-1:0]   cfg_base_i,
  input  logic [ADDR_W:0]     cfg_count_i,
  input  logic [DATA_W-1:0]   cfg_pattern_i,
  input  logic                cfg_mode_i,
  output logic                wr_req_o,
  input  logic                wr_gnt_i,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W/8-1:0] wr_be_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e              state_q, state_d;
  logic                init_q, init_d;     // post-reset clear still pending
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic                mode_q, mode_d;
  logic                err_q, err_d;

  logic [ADDR_W:0]     avail;
  logic [ADDR_W:0]     eff_count;
  logic                base_oob;
  logic                clipped;

  // Request range checks; avail is only meaningful when the base is in range.
  always_comb begin
    base_oob  = {1'b0, cfg_base_i} >= DepthW;
    avail     = DepthW - {1'b0, cfg_base_i};
    clipped   = cfg_count_i > avail;
    eff_count = clipped ? avail : cfg_count_i;
  end

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    pattern_d = pattern_q;
    mode_d    = mode_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (init_q) begin
          init_d    = 1'b0;
          addr_d    = '0;
          idx_d     = '0;
          rem_d     = DepthW;
          pattern_d = FILL_INIT;
          mode_d    = 1'b0;
          err_d     = 1'b0;
          state_d   = StFill;
        end else if (start_i) begin
          pattern_d = cfg_pattern_i;
          mode_d    = cfg_mode_i;
          addr_d    = cfg_base_i;
          idx_d     = '0;
          if (base_oob || eff_count == '0) begin
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            rem_d   = eff_count;
            err_d   = clipped;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (wr_gnt_i) begin
          if (rem_q == (ADDR_W + 1)'(1)) begin
            // Last word: keep the address in range, completion beats abort.
            rem_d   = '0;
            state_d = StDone;
          end else begin
            addr_d = addr_q + 1'b1;
            idx_d  = idx_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (abort_i) state_d = StIdle;
          end
        end else if (abort_i) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      init_q    <= (START_ON_RESET != 0);
      addr_q    <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      pattern_q <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
    end
  end

  // Address/data are forced to zero outside the fill so idle outputs stay quiet.
  always_comb begin
    wr_req_o  = (state_q == StFill);
    busy_o    = wr_req_o;
    wr_be_o   = {(DATA_W / 8){wr_req_o}};
    wr_addr_o = wr_req_o ? addr_q : '0;
    wr_data_o = '0;
    if (wr_req_o) wr_data_o = mode_q ? pattern_q + DATA_W'(idx_q) : pattern_q;
    done_o    = (state_q == StDone);
    cfg_err_o = done_o && err_q;
  end

endmodule

// File: tb/tb_vram_fill_engine.sv
// Directed self-checking bench for vram_fill_engine with default parameters.
module tb_vram_fill_engine;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        abort_i;
  logic [10:0] cfg_base_i;
  logic [11:0] cfg_count_i;
  logic [31:0] cfg_pattern_i;
  logic        cfg_mode_i;
  logic        wr_req_o;
  logic        wr_gnt_i;
  logic [10:0] wr_addr_o;
  logic [3:0]  wr_be_o;
  logic [31:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  vram_fill_engine u_dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .cfg_base_i   (cfg_base_i),
    .cfg_count_i  (cfg_count_i),
    .cfg_pattern_i(cfg_pattern_i),
    .cfg_mode_i   (cfg_mode_i),
    .wr_req_o     (wr_req_o),
    .wr_gnt_i     (wr_gnt_i),
    .wr_addr_o    (wr_addr_o),
    .wr_be_o      (wr_be_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cfg_err_o    (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cmd(input logic [10:0] base, input logic [11:0] count,
                     input logic [31:0] pat, input logic mode);
    cfg_base_i    = base;
    cfg_count_i   = count;
    cfg_pattern_i = pat;
    cfg_mode_i    = mode;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  // Expect one accepted write this cycle with gnt held high.
  task automatic expect_wr(input string tag, input logic [10:0] addr, input logic [31:0] data);
    check({tag, " req"}, 64'(wr_req_o), 64'd1);
    check({tag, " addr"}, 64'(wr_addr_o), 64'(addr));
    check({tag, " data"}, 64'(wr_data_o), 64'(data));
    tick();
  endtask

  task automatic expect_done(input string tag, input logic err);
    check({tag, " done"}, 64'(done_o), 64'd1);
    check({tag, " err"}, 64'(cfg_err_o), 64'(err));
    check({tag, " req0"}, 64'(wr_req_o), 64'd0);
    tick();
    check({tag, " done1cyc"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int k;
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; wr_gnt_i = 1'b1;
    cfg_base_i = '0; cfg_count_i = '0; cfg_pattern_i = '0; cfg_mode_i = 1'b0;

    // 1: reset then the power-on clear of 600 words
    repeat (3) tick();
    check("rst req", 64'(wr_req_o), 64'd0);
    check("rst outs", {wr_addr_o, wr_be_o, wr_data_o, busy_o, done_o, cfg_err_o}, 64'd0);
    reset_i = 1'b0;
    tick();
    check("clr busy", 64'(busy_o), 64'd1);
    check("clr be", 64'(wr_be_o), 64'hF);
    for (int i = 0; i < 600; i++) expect_wr("clr", 11'(i), 32'd0);
    expect_done("clr", 1'b0);

    // 2: incrementing fill at base 10
    cmd(11'd10, 12'd4, 32'h41, 1'b1);
    for (int i = 0; i < 4; i++) expect_wr("inc", 11'(10 + i), 32'h41 + 32'(i));
    expect_done("inc", 1'b0);

    // 3: same fill with a stalling grant 1,0,0,1,0,0,...
    cmd(11'd10, 12'd4, 32'h41, 1'b1);
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      wr_gnt_i = (c % 3 == 0);
      check("stall req", 64'(wr_req_o), 64'd1);
      check("stall addr", 64'(wr_addr_o), 64'(10 + k));
      check("stall data", 64'(wr_data_o), 64'(32'h41 + 32'(k)));
      tick();
      if (c % 3 == 0) k++;
    end
    wr_gnt_i = 1'b1;
    check("stall words", 64'(k), 64'd4);
    expect_done("stall", 1'b0);

    // 4: clipped request and empty request
    cmd(11'd598, 12'd5, 32'h5, 1'b0);
    expect_wr("clip", 11'd598, 32'h5);
    expect_wr("clip", 11'd599, 32'h5);
    expect_done("clip", 1'b1);
    cmd(11'd600, 12'd3, 32'h5, 1'b0);
    check("oob busy", 64'(busy_o), 64'd0);
    expect_done("oob", 1'b1);
    cmd(11'd4, 12'd0, 32'h5, 1'b0);
    expect_done("zero", 1'b1);

    // 5: incrementing data wraps modulo 2**32
    cmd(11'd0, 12'd3, 32'hFFFF_FFFF, 1'b1);
    expect_wr("wrap", 11'd0, 32'hFFFF_FFFF);
    expect_wr("wrap", 11'd1, 32'h0000_0000);
    expect_wr("wrap", 11'd2, 32'h0000_0001);
    expect_done("wrap", 1'b0);

    // 6a: abort after two accepts
    cmd(11'd20, 12'd8, 32'h7, 1'b0);
    expect_wr("abt", 11'd20, 32'h7);
    expect_wr("abt", 11'd21, 32'h7);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abt req", 64'(wr_req_o), 64'd0);
    check("abt done", 64'(done_o), 64'd0);
    check("abt err", 64'(cfg_err_o), 64'd0);
    tick();
    check("abt idle done", 64'(done_o), 64'd0);

    // 6b: reset mid-fill restarts the clear at word 0
    cmd(11'd5, 12'd10, 32'h9, 1'b1);
    expect_wr("mid", 11'd5, 32'h9);
    reset_i = 1'b1;
    tick();
    check("mid rst req", 64'(wr_req_o), 64'd0);
    reset_i = 1'b0;
    tick();
    expect_wr("reclr", 11'd0, 32'd0);
    expect_wr("reclr", 11'd1, 32'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("reclr abt req", 64'(wr_req_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
